pdm_playback: RTL

//  Playback counterpart of the PDM capture path: reads 16-bit packed PDM words from audio BRAM and

---
 rtl/pdm_playback.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pdm_playback.sv
// PDM playback: streams packed 16-bit PDM words from BRAM to the amplifier,
// one bit per CLK_DIV clocks, bit 0 first, with a one-word prefetch.
module pdm_playback #(
  parameter int MEM_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int CLK_DIV      = 50,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  play,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] end_address,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  read_enable,
  input  logic [MEM_WIDTH-1:0]  read_data,
  output logic                  pdm_out,
  output logic                  audio_sd,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [ADDR_WIDTH-1:0]     end_addr;
  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [MEM_WIDTH-1:0]      shift_reg;
  logic [MEM_WIDTH-1:0]      prefetch_reg;
  logic [3:0]                bit_index;
  logic [DIV_W-1:0]          div_cnt;
  logic [READ_LATENCY-1:0]   rd_pipe;
  logic                      data_ready;

  logic start;
  logic load;
  logic tick;
  logic wrap;
  logic finish;
  logic stop;

  logic [ADDR_WIDTH-1:0] cur_next;
  logic [ADDR_WIDTH-1:0] pf_base;
  logic [ADDR_WIDTH-1:0] pf_addr;
  logic                  pf_ok;

  assign data_ready = rd_pipe[READ_LATENCY-1];
  assign busy       = (state != IDLE);
  assign audio_sd   = (state == PLAY);

  assign cur_next = (cur_addr == end_addr) ? '0 : cur_addr + 1'b1;
  // Prefetch always targets the word after the one about to play.
  assign pf_base  = wrap ? cur_next : cur_addr;
  assign pf_addr  = (pf_base == end_addr) ? '0 : pf_base + 1'b1;
  assign pf_ok    = (pf_base != end_addr) || loop;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    load       = 1'b0;
    tick       = 1'b0;
    wrap       = 1'b0;
    finish     = 1'b0;
    stop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (play) begin
          start      = 1'b1;
          next_state = PRIME;
        end
      end
      PRIME: begin
        if (!play) begin
          stop       = 1'b1;
          next_state = IDLE;
        end else if (data_ready) begin
          load       = 1'b1;
          next_state = PLAY;
        end
      end
      PLAY: begin
        if (!play) begin
          stop       = 1'b1;
          next_state = IDLE;
        end else if (div_cnt == DIV_LAST) begin
          tick = 1'b1;
          if (bit_index == 4'hF) begin
            if (cur_addr == end_addr && !loop) begin
              finish     = 1'b1;
              next_state = IDLE;
            end else begin
              wrap = 1'b1;
            end
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      end_addr     <= '0;
      cur_addr     <= '0;
      shift_reg    <= '0;
      prefetch_reg <= '0;
      bit_index    <= '0;
      div_cnt      <= '0;
      rd_pipe      <= '0;
      read_address <= '0;
      read_enable  <= 1'b0;
      pdm_out      <= 1'b0;
      done         <= 1'b0;
    end else begin
      read_enable <= 1'b0;
      done        <= finish;
      rd_pipe     <= (rd_pipe << 1) | READ_LATENCY'(read_enable);
      if (start) begin
        end_addr     <= end_address;
        cur_addr     <= '0;
        read_address <= '0;
        read_enable  <= 1'b1;
      end
      if (load) begin
        shift_reg <= read_data;
        pdm_out   <= read_data[0];
        bit_index <= '0;
        div_cnt   <= '0;
      end
      if (state == PLAY && data_ready) prefetch_reg <= read_data;
      if ((load || wrap) && pf_ok) begin
        read_address <= pf_addr;
        read_enable  <= 1'b1;
      end
      if (state == PLAY && !tick) div_cnt <= div_cnt + 1'b1;
      if (tick) begin
        div_cnt   <= '0;
        bit_index <= bit_index + 4'd1;
        pdm_out   <= shift_reg[bit_index + 4'd1];
      end
      if (wrap) begin
        shift_reg <= prefetch_reg;
        pdm_out   <= prefetch_reg[0];
        cur_addr  <= cur_next;
      end
      if (finish || stop) begin
        pdm_out     <= 1'b0;
        read_enable <= 1'b0;
        rd_pipe     <= '0;
        div_cnt     <= '0;
        bit_index   <= '0;
      end
    end
  end

endmodule
